uram_burst_reader: RTL

Read-side initiator for the 16-bit URAM word memory, which has a fixed read latency of 2 cycles, no read enable and no backpressure. Accepts a burst command (base address, word count), issues one read address per cycle, tracks in-flight reads, and delivers the returned words on a ready/valid stream. A credit-limited output FIFO absorbs the fixed latency so a stalled consumer never loses data. Sits between the memory's read port and the consumer, such as instruction fetch or scan-out; the memory write port is not touched.

---
 rtl/uram_pkg.sv | 22 ++
 rtl/uram_read_fifo.sv | 73 +++++++
 rtl/uram_burst_reader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uram_pkg.sv
// rtl/uram_pkg.sv - shared constants and types for the URAM burst reader
package uram_pkg;

  localparam int URAM_WORD_WIDTH   = 16;
  localparam int URAM_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } burst_state_t;

  // One returned word plus the end-of-burst marker that travelled with it.
  typedef struct packed {
    logic                       last;
    logic [URAM_WORD_WIDTH-1:0] data;
  } fifo_entry_t;

  localparam int FIFO_ENTRY_WIDTH = $bits(fifo_entry_t);

endpackage

// File: rtl/uram_read_fifo.sv
// rtl/uram_read_fifo.sv - synchronous output FIFO with same-cycle push/pop
module uram_read_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 17,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int              PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointer and occupancy update; a push into a full FIFO is taken only when a pop frees the slot.
  always_comb begin
    do_pop  = pop_i & (count_q != '0);
    do_push = push_i & ((count_q != FULL_COUNT) | do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the FIFO.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage write; contents are never read while empty so they need no reset.
  always_ff @(posedge clock_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rptr_q];
  assign full_o     = (count_q == FULL_COUNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/uram_burst_reader.sv
// rtl/uram_burst_reader.sv - burst read initiator for the fixed-latency URAM read port
module uram_burst_reader
  import uram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 14,
  parameter int READ_LATENCY  = URAM_READ_LATENCY,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [ADDRESS_WIDTH-1:0]   cmd_base_i,
  input  logic [ADDRESS_WIDTH:0]     cmd_count_i,
  output logic [ADDRESS_WIDTH-1:0]   raddr_o,
  input  logic [URAM_WORD_WIDTH-1:0] rdata_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [URAM_WORD_WIDTH-1:0] out_data_o,
  output logic                       out_last_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int                     CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDRESS_WIDTH:0] COUNT_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  burst_state_t               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0]   raddr_q, raddr_d;
  logic [ADDRESS_WIDTH:0]     remaining_q, remaining_d;
  logic [READ_LATENCY:0]      v_q, last_q;
  logic                       issue, issue_last, can_issue;
  logic                       pop_now, push_valid, fifo_push;
  logic                       fifo_full, fifo_empty;
  logic [CW-1:0]              fifo_count;
  logic [FIFO_ENTRY_WIDTH-1:0] head_bits;
  fifo_entry_t                push_entry, head_entry;
  int                         credit_need;

  assign out_valid_o = ~fifo_empty;
  assign pop_now     = out_valid_o & out_ready_i;

  // A read may only launch if its word is guaranteed a FIFO slot when it returns.
  always_comb begin
    credit_need = int'(fifo_count) + $countones(v_q) - int'(pop_now) + 1;
    can_issue   = (credit_need <= FIFO_DEPTH);
  end

  // Burst FSM and address issue. The accepting handshake itself launches the first
  // read so that the first address is on the port the cycle after the command.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    raddr_d     = raddr_q;
    remaining_d = remaining_q;
    issue       = 1'b0;
    issue_last  = 1'b0;
    cmd_ready_o = (state_q == IDLE);
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_count_i == '0) begin
            state_d = DONE;
          end else begin
            state_d     = ISSUE;
            issue       = 1'b1;
            issue_last  = (cmd_count_i == COUNT_ONE);
            raddr_d     = cmd_base_i;
            addr_d      = cmd_base_i + 1'b1;
            remaining_d = cmd_count_i - COUNT_ONE;
          end
        end
      end
      ISSUE: begin
        if (remaining_q == '0) begin
          state_d = DRAIN;
        end else if (can_issue) begin
          issue       = 1'b1;
          issue_last  = (remaining_q == COUNT_ONE);
          raddr_d     = addr_q;
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - COUNT_ONE;
          if (remaining_q == COUNT_ONE) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop_now && out_last_o) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and the in-flight valid/last pipeline; reset drops in-flight reads.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      raddr_q     <= '0;
      remaining_q <= '0;
      v_q         <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      raddr_q     <= raddr_d;
      remaining_q <= remaining_d;
      v_q         <= {v_q[READ_LATENCY-1:0], issue};
      last_q      <= {last_q[READ_LATENCY-1:0], issue_last};
    end
  end

  assign raddr_o    = raddr_q;
  assign push_valid = v_q[READ_LATENCY];
  assign push_entry = '{last: last_q[READ_LATENCY], data: rdata_i};
  assign fifo_push  = push_valid & (~fifo_full | pop_now);

  uram_read_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_ENTRY_WIDTH)
  ) u_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (pop_now),
    .pop_data_o  (head_bits),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign head_entry = fifo_entry_t'(head_bits);
  assign out_data_o = fifo_empty ? '0   : head_entry.data;
  assign out_last_o = fifo_empty ? 1'b0 : head_entry.last;

endmodule
